// File: rtl/mmio_port_bank_pkg.sv
// rtl/mmio_port_bank_pkg.sv - shared constants for the MMIO port bank
package mmio_port_bank_pkg;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h2000;

    // Control register offsets, relative to BASE_ADDR + NUM_PORTS
    localparam int OFS_STATUS = 0;
    localparam int OFS_IRQEN  = 1;

    function automatic logic [15:0] reg_addr(input logic [15:0] base, input int num_ports, input int ofs);
        return base + 16'(num_ports + ofs);
    endfunction

endpackage

// File: rtl/mmio_port_bank_if.sv
// rtl/mmio_port_bank_if.sv - processor-side memory bus of the MMIO port bank
interface mmio_port_bank_if;

    logic [15:0] memAddr;
    logic        re_L;
    logic        we_L;
    logic [15:0] wrData;
    logic [15:0] rdData;
    logic        rdDrive_L;

    modport master (
        output memAddr, re_L, we_L, wrData,
        input  rdData, rdDrive_L
    );

    modport slave (
        input  memAddr, re_L, we_L, wrData,
        output rdData, rdDrive_L
    );

endinterface

// File: rtl/mmio_sync.sv
// rtl/mmio_sync.sv - two-flop synchronizer for an asynchronous input word
module mmio_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mmio_port_bank.sv
// rtl/mmio_port_bank.sv - bank of synchronized input / registered output ports
// with sticky change status and a maskable level interrupt
module mmio_port_bank
    import mmio_port_bank_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          NUM_PORTS = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    mmio_port_bank_if.slave        bus,
    input  logic [NUM_PORTS*16-1:0] SW,
    output logic [NUM_PORTS*16-1:0] LEDR,
    output logic                   irq
);

    localparam logic [15:0] STATUS_ADDR = reg_addr(BASE_ADDR, NUM_PORTS, OFS_STATUS);
    localparam logic [15:0] IRQEN_ADDR  = reg_addr(BASE_ADDR, NUM_PORTS, OFS_IRQEN);

    logic [15:0] sync_w [NUM_PORTS];

    logic [NUM_PORTS*16-1:0] led_q, led_d;
    logic [NUM_PORTS*16-1:0] prev_q, prev_d;
    logic [NUM_PORTS-1:0]    status_q, status_d;
    logic [NUM_PORTS-1:0]    irqen_q, irqen_d;
    logic                    irq_q, irq_d;

    logic [NUM_PORTS-1:0] hit_data;
    logic                 hit_status, hit_irqen, mapped;
    logic                 rd_en, wr_en;
    logic [15:0]          rd_value;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        mmio_sync #(.WIDTH(16)) u_sync (
            .clock (clock),
            .reset (reset),
            .d     (SW[i*16 +: 16]),
            .q     (sync_w[i])
        );
    end

    // Exact 16-bit compares; BASE_ADDR + offset wraps naturally
    always_comb begin
        hit_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hit_data[i] = (bus.memAddr == BASE_ADDR + 16'(i));
        end
        hit_status = (bus.memAddr == STATUS_ADDR);
        hit_irqen  = (bus.memAddr == IRQEN_ADDR);
        mapped     = (|hit_data) | hit_status | hit_irqen;
        rd_en      = ~bus.re_L & mapped;
        wr_en      = ~bus.we_L;
    end

    always_comb begin
        rd_value = 16'h0000;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (hit_data[i]) rd_value = sync_w[i];
        end
        if (hit_status) rd_value = 16'(status_q);
        if (hit_irqen)  rd_value = 16'(irqen_q);
    end

    assign bus.rdDrive_L = ~rd_en;
    assign bus.rdData    = rd_en ? rd_value : 16'h0000;

    always_comb begin
        led_d    = led_q;
        prev_d   = prev_q;
        status_d = status_q;
        irqen_d  = irqen_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            prev_d[i*16 +: 16] = sync_w[i];
            if (wr_en && hit_data[i]) led_d[i*16 +: 16] = bus.wrData;
        end
        if (wr_en && hit_status) status_d = status_q & ~bus.wrData[NUM_PORTS-1:0];
        if (wr_en && hit_irqen)  irqen_d  = bus.wrData[NUM_PORTS-1:0];
        // Change events are applied after the W1C so a coincident set wins
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sync_w[i] != prev_q[i*16 +: 16]) status_d[i] = 1'b1;
        end
        irq_d = |(status_q & irqen_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q    <= '0;
            prev_q   <= '0;
            status_q <= '0;
            irqen_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            prev_q   <= prev_d;
            status_q <= status_d;
            irqen_q  <= irqen_d;
            irq_q    <= irq_d;
        end
    end

    assign LEDR = led_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// tb/tb_mmio_port_bank.sv - directed self-checking bench for mmio_port_bank
module tb_mmio_port_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] SW;
    logic [31:0] LEDR;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    mmio_port_bank_if bus ();

    mmio_port_bank #(.BASE_ADDR(16'h2000), .NUM_PORTS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .SW    (SW),
        .LEDR  (LEDR),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        bus.memAddr = a;
        bus.wrData  = d;
        bus.we_L    = 1'b0;
        @(negedge clock);
        bus.we_L    = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        bus.memAddr = a;
        bus.re_L    = 1'b0;
        #1;
        chk({tag, "_drv"}, {31'd0, bus.rdDrive_L}, 32'd0);
        chk(tag, {16'd0, bus.rdData}, {16'd0, exp});
        bus.re_L    = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        SW          = 32'h0;
        bus.memAddr = 16'h0;
        bus.wrData  = 16'h0;
        bus.re_L    = 1'b1;
        bus.we_L    = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        chk("rst_ledr", LEDR, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(16'h2002, 16'h0000, "rst_status");

        // Reset with LEDR previously all ones, plus a write in the reset cycle
        wr(16'h2000, 16'hFFFF);
        chk("pre_rst_ledr", LEDR, 32'h0000_FFFF);
        wr(16'h2003, 16'h0001);
        @(negedge clock);
        reset       = 1'b1;
        bus.memAddr = 16'h2001;
        bus.wrData  = 16'h5555;
        bus.we_L    = 1'b0;
        @(negedge clock);
        reset       = 1'b0;
        bus.we_L    = 1'b1;
        chk("rst2_ledr", LEDR, 32'h0);
        chk("rst2_irq", {31'd0, irq}, 32'd0);
        rd(16'h2002, 16'h0000, "rst2_status");
        rd(16'h2003, 16'h0000, "rst2_irqen");

        // Output writes
        wr(16'h2000, 16'h1234);
        chk("led0_wr", LEDR, 32'h0000_1234);
        wr(16'h2001, 16'hA5A5);
        chk("led1_wr", LEDR, 32'hA5A5_1234);

        // Input synchronizer latency and change detection
        @(negedge clock);
        SW[15:0] = 16'h0003;
        @(negedge clock);
        rd(16'h2000, 16'h0000, "sync_1edge");
        @(negedge clock);
        rd(16'h2000, 16'h0003, "sync_2edge");
        @(negedge clock);
        rd(16'h2002, 16'h0001, "status_set");
        @(negedge clock);
        rd(16'h2002, 16'h0001, "status_sticky");

        // Interrupt enable, then W1C
        wr(16'h2003, 16'h0001);
        chk("irq_lat0", {31'd0, irq}, 32'd0);
        @(negedge clock);
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr(16'h2002, 16'h0001);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clock);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd(16'h2002, 16'h0000, "status_w1c");

        // Port 1 change, then coincident toggle and W1C
        SW[31:16] = 16'h0001;
        repeat (4) @(negedge clock);
        rd(16'h2002, 16'h0002, "status_p1");
        chk("irq_masked", {31'd0, irq}, 32'd0);
        SW[16] = 1'b0;
        repeat (2) @(negedge clock);
        bus.memAddr = 16'h2002;
        bus.wrData  = 16'h0002;
        bus.we_L    = 1'b0;
        @(negedge clock);
        bus.we_L    = 1'b1;
        rd(16'h2002, 16'h0002, "set_wins");
        wr(16'h2002, 16'h0002);
        rd(16'h2002, 16'h0000, "w1c_p1");

        // Unmapped address
        bus.memAddr = 16'h2004;
        bus.re_L    = 1'b0;
        #1;
        chk("unmap_drv", {31'd0, bus.rdDrive_L}, 32'd1);
        chk("unmap_data", {16'd0, bus.rdData}, 32'd0);
        bus.re_L    = 1'b1;
        wr(16'h2004, 16'hFFFF);
        chk("unmap_ledr", LEDR, 32'hA5A5_1234);
        rd(16'h2003, 16'h0001, "unmap_irqen");
        rd(16'h2002, 16'h0000, "unmap_status");

        // Simultaneous read and write of IRQEN
        @(negedge clock);
        bus.memAddr = 16'h2003;
        bus.wrData  = 16'hFFFF;
        bus.we_L    = 1'b0;
        bus.re_L    = 1'b0;
        #1;
        chk("raw_pre", {16'd0, bus.rdData}, 32'h0000_0001);
        @(negedge clock);
        bus.we_L    = 1'b1;
        bus.re_L    = 1'b1;
        rd(16'h2003, 16'h0003, "raw_post");
        rd(16'h2001, 16'h0000, "data1_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_port_bank.md
MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'h2000: first word address of the bank.
REQ-002 The block SHALL have parameter NUM_PORTS, default 2: number of 16-bit input/output port pairs, legal range 1..8.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port memAddr, input, 16 bits: bus address.
REQ-006 The block SHALL have port re_L, input, 1 bit: read strobe, active-low.
REQ-007 The block SHALL have port we_L, input, 1 bit: write strobe, active-low.
REQ-008 The block SHALL have port wrData, input, 16 bits: write data, taken from the MDR.
REQ-009 The block SHALL have port rdData, output, 16 bits: read data for the MDR tristate driver.
REQ-010 The block SHALL have port rdDrive_L, output, 1 bit: active-low enable for the rdData tristate driver.
REQ-011 The block SHALL have port SW, input, NUM_PORTS*16 bits: asynchronous external inputs; port i occupies bits [16i+15:16i].
REQ-012 The block SHALL have port LEDR, output, NUM_PORTS*16 bits: registered external outputs, packed the same way as SW.
REQ-013 The block SHALL have port irq, output, 1 bit: level interrupt request, active-high.

Function
REQ-014 The block SHALL decode the following address map:
- BASE_ADDR+i (i < NUM_PORTS): DATA[i].
- BASE_ADDR+NUM_PORTS: STATUS.
- BASE_ADDR+NUM_PORTS+1: IRQEN.
- All other addresses are unmapped.
REQ-015 The block SHALL pass each SW port through a 2-flop synchronizer, followed by a third "previous" flop per port.
REQ-016 A read of DATA[i] SHALL return the synchronizer second-stage value of port i.
REQ-017 A write to DATA[i] SHALL load wrData into LEDR port i at the clock edge that ends the we_L-low cycle (1-cycle write latency).
REQ-018 The block SHALL set sticky STATUS bit i at the next edge whenever synchronized port i differs from its previous-flop value.
REQ-019 STATUS bits [15:NUM_PORTS] SHALL always read 0.
REQ-020 Writing STATUS SHALL be write-1-to-clear: a bit is cleared where wrData is 1 and left unchanged where wrData is 0.
REQ-021 If a change event and a W1C clear hit the same STATUS bit in the same cycle, the set SHALL win.
REQ-022 IRQEN SHALL be read/write: bits [NUM_PORTS-1:0] are stored, and the upper bits read as 0.
REQ-023 irq SHALL be registered and equal OR(STATUS & IRQEN) one cycle after that condition holds; it stays asserted until STATUS is cleared or the mask is cleared.
REQ-024 rdDrive_L SHALL be combinational: low iff re_L is low and memAddr hits a mapped address.
REQ-025 rdData SHALL be combinational from registered state; it is 16'h0000 when rdDrive_L is high.
REQ-026 Reads SHALL have no side effects; STATUS is not cleared on read.
REQ-027 Writes to unmapped addresses SHALL be ignored, and reads of unmapped addresses SHALL leave rdDrive_L high.
REQ-028 If re_L and we_L are both low for the same address, the read SHALL return the pre-write value and the write SHALL take effect at the edge.
REQ-029 Address decode SHALL be exact 16-bit compare; BASE_ADDR+offset wraps modulo 2^16.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL clear LEDR, STATUS, IRQEN, irq and all synchronizer/previous flops to 0.
REQ-031 Reset SHALL take priority over a simultaneous write, and over a change event in the same cycle.
REQ-032 No change event SHALL be flagged in the first cycles after reset deassertion unless synchronized SW differs from the previous flop, which is 0 after reset.

Structure
REQ-033 Register offsets (OFS_STATUS, OFS_IRQEN as NUM_PORTS-relative) and the default base 16'h2000 SHALL live in the shared constants package.
REQ-034 The block SHALL instantiate one sub-module, mmio_sync (parametrised-width 2-flop synchronizer), once per port.
REQ-035 The bus-facing tristate driver SHALL stay in the datapath, enabled by rdDrive_L.

Verification
REQ-036 Bench SHALL cover: reset high for 1 edge with LEDR previously 16'hFFFF -> LEDR=0, STATUS=0, irq=0 after that edge.
REQ-037 Bench SHALL cover: NUM_PORTS=2, write 16'hA5A5 to 16'h2001 -> LEDR[31:16]=16'hA5A5 the next cycle, LEDR[15:0] unchanged.
REQ-038 Bench SHALL cover: SW[15:0] 0->16'h0003 -> DATA[0] reads 16'h0003 within 2 cycles; STATUS (16'h2002) reads 16'h0001.
REQ-039 Bench SHALL cover: IRQEN=16'h0001 with STATUS bit 0 set -> irq=1; write 16'h0001 to STATUS -> irq=0 one cycle later.
REQ-040 Bench SHALL cover: SW[16] toggles in the same cycle as W1C 16'h0002 -> STATUS bit 1 remains 1.
REQ-041 Bench SHALL cover: read 16'h2004 (unmapped) -> rdDrive_L=1, rdData=0; write to 16'h2004 -> no register changes.
